grant_burst_mux: RTL and testbench

Downstream consumer of the 4-requester fixed-priority arbiter. It takes the arbiter's one-hot `grant`, locks onto the granted requester, and moves a burst of `BEATS` data words from that requester onto a single shared output channel with valid/ready handshake. It releases the lock only when the burst is complete. Per-requester `ack` pulses tell each source when a word has been consumed.

---
 rtl/grant_burst_mux.sv | 92 +++++++++
 tb/tb_grant_burst_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/grant_burst_mux.sv
// Locks onto the one-hot grant owner and moves BEATS words to a shared valid/ready channel.
// Latency: one cycle from grant sample to first valid; out_valid/out_data hold while out_ready is low.
module grant_burst_mux #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         grant,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         ack,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic [1:0] owner_q;
  logic       err_q;

  logic       accept;
  logic       grant_multi;
  logic       grant_one;
  logic [1:0] grant_idx;

  assign accept      = (state_q == XFER) && out_ready;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign grant_multi = |(grant & (grant - 4'd1));
  assign grant_one   = (grant != 4'd0) && !grant_multi;

  always_comb begin
    grant_idx = 2'd0;
    case (grant)
      4'b0010: grant_idx = 2'd1;
      4'b0100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      owner_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_multi) begin
            err_q <= 1'b1;
          end else if (grant_one) begin
            owner_q <= grant_idx;
            cnt_q   <= 5'd0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_BEAT) state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == XFER);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RELEASE);
  assign err       = err_q;
  assign owner     = owner_q;
  assign out_data  = data_in[int'(owner_q)*WIDTH +: WIDTH];
  assign ack       = accept ? (4'd1 << owner_q) : 4'd0;

endmodule

// File: tb/tb_grant_burst_mux.sv
// Table-driven cycle vectors plus a data scoreboard for grant_burst_mux (WIDTH=8, BEATS=4).
module tb_grant_burst_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  grant = 4'd0;
  logic [31:0] data_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] words [4] = '{8'h11, 8'h22, 8'hA5, 8'h3C};
  assign data_in = {words[3], words[2], words[1], words[0]};

  grant_burst_mux #(.WIDTH(8), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .grant(grant), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ack(ack), .owner(owner), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] grant;
    logic       rdy;
    logic       start;
    logic       v, b, d, e;
    logic [1:0] own;
    logic [3:0] ack;
    logic [7:0] dat;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] ack;
  } sb_t;

  vec_t vt[$];
  sb_t  sbq[$];

  task automatic add(input logic r, input logic [3:0] g, input logic rd, input logic st,
                     input logic v, input logic b, input logic d, input logic e,
                     input logic [1:0] o, input logic [3:0] a, input logic [7:0] dt);
    vec_t x;
    x.rst = r; x.grant = g; x.rdy = rd; x.start = st;
    x.v = v; x.b = b; x.d = d; x.e = e; x.own = o; x.ack = a; x.dat = dt;
    vt.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] g2i(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push_burst(input logic [3:0] g);
    sb_t s;
    s.dat = words[g2i(g)];
    s.ack = g;
    for (int k = 0; k < 4; k++) sbq.push_back(s);
  endtask

  // Called at the falling edge: pops one expected word per accepted beat.
  task automatic sb_sample(output bit acc);
    sb_t s;
    acc = 0;
    if (out_valid && out_ready) begin
      acc = 1;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got beat %0h expected none", out_data);
      end else begin
        s = sbq.pop_front();
        chk("sb_data", 32'(out_data), 32'(s.dat));
        chk("sb_ack", 32'(ack), 32'(s.ack));
      end
    end
  endtask

  initial begin
    bit acc;
    int acks;
    bit seen_done;

    // rst grant rdy start | valid busy done err owner ack data
    add(1, 4'b0100, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h11);
    add(1, 4'b0100, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h11);
    // basic burst, requester 2
    add(0, 4'b0100, 1, 1,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    for (int k = 0; k < 4; k++) add(0, 4'b0000, 1, 0, 1, 1, 0, 0, 2'd2, 4'b0100, 8'hA5);
    add(0, 4'b0000, 1, 0,  0, 1, 1, 0, 2'd2, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  0, 0, 0, 0, 2'd2, 4'b0000, 8'h00);
    // backpressure, ready alternating
    add(0, 4'b0100, 0, 1,  0, 0, 0, 0, 2'd2, 4'b0000, 8'h00);
    for (int k = 0; k < 7; k++)
      add(0, 4'b0000, (k % 2 == 0), 0, 1, 1, 0, 0, 2'd2, (k % 2 == 0) ? 4'b0100 : 4'b0000, 8'hA5);
    add(0, 4'b0000, 0, 0,  0, 1, 1, 0, 2'd2, 4'b0000, 8'h00);
    add(0, 4'b0000, 0, 0,  0, 0, 0, 0, 2'd2, 4'b0000, 8'h00);
    // grant change mid-burst: requester 3, then 0 only after release
    add(0, 4'b1000, 1, 1,  0, 0, 0, 0, 2'd2, 4'b0000, 8'h00);
    add(0, 4'b1000, 1, 0,  1, 1, 0, 0, 2'd3, 4'b1000, 8'h3C);
    for (int k = 0; k < 3; k++) add(0, 4'b0001, 1, 0, 1, 1, 0, 0, 2'd3, 4'b1000, 8'h3C);
    add(0, 4'b0001, 1, 0,  0, 1, 1, 0, 2'd3, 4'b0000, 8'h00);
    add(0, 4'b0001, 1, 1,  0, 0, 0, 0, 2'd3, 4'b0000, 8'h00);
    for (int k = 0; k < 4; k++) add(0, 4'b0000, 1, 0, 1, 1, 0, 0, 2'd0, 4'b0001, 8'h11);
    add(0, 4'b0000, 1, 0,  0, 1, 1, 0, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    // illegal and empty grants
    add(0, 4'b0011, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b1100, 1, 0,  0, 0, 0, 1, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  0, 0, 0, 1, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b0000, 0, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    // reset after two beats of an owner-1 burst, then a fresh burst
    add(0, 4'b0010, 1, 1,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  1, 1, 0, 0, 2'd1, 4'b0010, 8'h22);
    add(0, 4'b0000, 1, 0,  1, 1, 0, 0, 2'd1, 4'b0010, 8'h22);
    add(1, 4'b0000, 1, 0,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h11);
    add(0, 4'b0010, 1, 1,  0, 0, 0, 0, 2'd0, 4'b0000, 8'h00);
    for (int k = 0; k < 4; k++) add(0, 4'b0000, 1, 0, 1, 1, 0, 0, 2'd1, 4'b0010, 8'h22);
    add(0, 4'b0000, 1, 0,  0, 1, 1, 0, 2'd1, 4'b0000, 8'h00);
    add(0, 4'b0000, 1, 0,  0, 0, 0, 0, 2'd1, 4'b0000, 8'h00);

    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++) begin
      rst       = vt[i].rst;
      grant     = vt[i].grant;
      out_ready = vt[i].rdy;
      if (vt[i].rst) sbq.delete();
      if (vt[i].start) push_burst(vt[i].grant);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].v));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].d));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vt[i].e));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(vt[i].own));
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(vt[i].ack));
      if (vt[i].v || vt[i].rst)
        chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].dat));
      sb_sample(acc);
      @(posedge clk);
      #1;
    end

    // Long stall on requester 3, then drain with a bounded wait for done.
    grant = 4'b1000;
    out_ready = 1'b0;
    push_burst(4'b1000);
    @(posedge clk);
    #1;
    grant = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d out_data", k), 32'(out_data), 32'h3C);
      chk($sformatf("stall%0d ack", k), 32'(ack), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    acks = 0;
    seen_done = 0;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      @(negedge clk);
      sb_sample(acc);
      if (acc) acks++;
      if (done) seen_done = 1;
      @(posedge clk);
      #1;
    end
    chk("drain done_seen", 32'(seen_done), 32'd1);
    chk("drain ack_count", 32'(acks), 32'd4);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
